// File: rtl/encoder_pending.sv
// ---------------------------------------------------------------------------
// encoder_pending
//
// Sequential N-to-log2(N) encoder. Request bits arriving on Din (gated by En)
// are merged into a pending register and then emitted one at a time as a
// binary index, lowest index first, over a valid/ready handshake. A request
// re-asserted while its bit is still pending is merged and lost; that loss
// is recorded in a sticky overflow flag.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset
//   En      in   1  request enable; Din is ignored while low
//   Din     in   N  request bits, sampled every clock while En=1
//   Do      out  W  binary index of the served request (valid with Dv)
//   Dv      out  1  Do valid
//   Dr      in   1  consumer ready; transfer on an edge with Dv=1 and Dr=1
//   Ovf     out  1  sticky overflow flag
//   OvfClr  in   1  synchronous clear of Ovf (a same-edge overflow wins)
// ---------------------------------------------------------------------------
module encoder_pending #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         En,
    input  logic [N-1:0] Din,
    output logic [W-1:0] Do,
    output logic         Dv,
    input  logic         Dr,
    output logic         Ovf,
    input  logic         OvfClr
);

    logic [N-1:0] pend_q;
    logic [W-1:0] idx_q;
    logic         vld_q;
    logic         ovf_q;

    logic [N-1:0] req;
    logic [N-1:0] cand;
    logic [N-1:0] cand_cleared;
    logic [W-1:0] lsb_idx;
    logic         lsb_found;
    logic         slot_free;
    logic         ovf_set;

    // NOTE: every signal written in this block gets a default before any
    // conditional logic, so no path leaves a value unassigned and no latch
    // is inferred.
    always_comb begin
        req          = Din & {N{En}};
        cand         = pend_q | req;
        slot_free    = !vld_q || Dr;
        lsb_idx      = '0;
        lsb_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!lsb_found && cand[i]) begin
                lsb_idx   = W'(i);
                lsb_found = 1'b1;
            end
        end
        cand_cleared = cand & ~(N'(1) << lsb_idx);
        // Only the pending register counts as a duplicate; re-requesting the
        // bit currently held in Do simply queues it again.
        ovf_set      = |(req & pend_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (slot_free) begin
                if (lsb_found) begin
                    idx_q  <= lsb_idx;
                    vld_q  <= 1'b1;
                    pend_q <= cand_cleared;
                end else begin
                    // Do keeps its last value; it is only meaningful with Dv.
                    vld_q  <= 1'b0;
                    pend_q <= '0;
                end
            end else begin
                // Stalled: the held transfer is never preempted, but new
                // requests keep accumulating.
                pend_q <= cand;
            end
            ovf_q <= ovf_set || (ovf_q && !OvfClr);
        end
    end

    assign Do  = idx_q;
    assign Dv  = vld_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_encoder_pending.sv
// ---------------------------------------------------------------------------
// tb_encoder_pending
//
// Directed bench for encoder_pending (N=4, W=2). Each scenario task drives
// its own vectors and compares DUT outputs against hand-computed values one
// time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_encoder_pending;

    logic       clk;
    logic       rst_n;
    logic       En;
    logic [3:0] Din;
    logic [1:0] Do;
    logic       Dv;
    logic       Dr;
    logic       Ovf;
    logic       OvfClr;

    int vectors;
    int miscompares;

    encoder_pending #(.N(4), .W(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (En),
        .Din    (Din),
        .Do     (Do),
        .Dv     (Dv),
        .Dr     (Dr),
        .Ovf    (Ovf),
        .OvfClr (OvfClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling / re-driving.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; En = 1'b0; Din = 4'b0000; Dr = 1'b0; OvfClr = 1'b0;
        cycle();
        cycle();
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b0_00_0) begin
            miscompares++;
            $display("FAIL reset_init: Dv/Do/Ovf=%b/%0d/%b want 0/0/0", Dv, Do, Ovf);
        end
        rst_n = 1'b1;
        cycle();
        vectors++;
        if ({Dv, Ovf} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: Dv/Ovf=%b/%b want 0/0", Dv, Ovf);
        end
    endtask

    task automatic test_single();
        En = 1'b1; Dr = 1'b1; Din = 4'b0100;
        cycle();
        Din = 4'b0000;
        vectors++;
        if ({Dv, Do} !== 3'b1_10) begin
            miscompares++;
            $display("FAIL single_hit: Dv/Do=%b/%0d want 1/2", Dv, Do);
        end
        cycle();
        vectors++;
        if (Dv !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: Dv=%b want 0", Dv);
        end
    endtask

    task automatic test_multi_hot();
        logic [1:0] exp_idx [3];
        exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd3;
        En = 1'b1; Dr = 1'b1; Din = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            cycle();
            Din = 4'b0000;
            vectors++;
            if ({Dv, Do} !== {1'b1, exp_idx[k]}) begin
                miscompares++;
                $display("FAIL multi_hot[%0d]: Dv/Do=%b/%0d want 1/%0d", k, Dv, Do, exp_idx[k]);
            end
        end
        cycle();
        vectors++;
        if (Dv !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_hot_done: Dv=%b want 0", Dv);
        end
    endtask

    task automatic test_backpressure();
        En = 1'b1; Dr = 1'b0; Din = 4'b0010;
        cycle();
        Din = 4'b0001;
        cycle();
        Din = 4'b0000;
        // Lower index 0 arrived during the stall; held index 1 must stay.
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({Dv, Do} !== 3'b1_01) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: Dv/Do=%b/%0d want 1/1", k, Dv, Do);
            end
            cycle();
        end
        Dr = 1'b1;
        cycle();
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b1_00_0) begin
            miscompares++;
            $display("FAIL stall_release: Dv/Do/Ovf=%b/%0d/%b want 1/0/0", Dv, Do, Ovf);
        end
        cycle();
        vectors++;
        if (Dv !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: Dv=%b want 0", Dv);
        end
    endtask

    task automatic test_overflow();
        En = 1'b1; Dr = 1'b0; Din = 4'b0001;
        cycle();
        Din = 4'b0100;
        cycle();
        vectors++;
        if (Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_first_req: Ovf=%b want 0", Ovf);
        end
        cycle();
        Din = 4'b0000;
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b1_00_1) begin
            miscompares++;
            $display("FAIL ovf_dup: Dv/Do/Ovf=%b/%0d/%b want 1/0/1", Dv, Do, Ovf);
        end
        Dr = 1'b1;
        cycle();
        vectors++;
        if ({Dv, Do} !== 3'b1_10) begin
            miscompares++;
            $display("FAIL ovf_serve: Dv/Do=%b/%0d want 1/2", Dv, Do);
        end
        cycle();
        vectors++;
        if ({Dv, Ovf} !== 2'b01) begin
            miscompares++;
            $display("FAIL ovf_once: Dv/Ovf=%b/%b want 0/1", Dv, Ovf);
        end
        OvfClr = 1'b1;
        cycle();
        OvfClr = 1'b0;
        vectors++;
        if (Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: Ovf=%b want 0", Ovf);
        end
        // Re-requesting the bit held in Do is not an overflow.
        Dr = 1'b0; Din = 4'b0001;
        cycle();
        cycle();
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b1_00_0) begin
            miscompares++;
            $display("FAIL ovf_held_rereq: Dv/Do/Ovf=%b/%0d/%b want 1/0/0", Dv, Do, Ovf);
        end
        // Now bit 0 is pending; a duplicate on the clear edge keeps Ovf set.
        OvfClr = 1'b1;
        cycle();
        vectors++;
        if (Ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: Ovf=%b want 1", Ovf);
        end
        Din = 4'b0000; Dr = 1'b1;
        cycle();
        OvfClr = 1'b0;
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b1_00_0) begin
            miscompares++;
            $display("FAIL ovf_requeued: Dv/Do/Ovf=%b/%0d/%b want 1/0/0", Dv, Do, Ovf);
        end
        cycle();
        vectors++;
        if (Dv !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_final_drain: Dv=%b want 0", Dv);
        end
    endtask

    task automatic test_enable_gating();
        En = 1'b0; Dr = 1'b1; Din = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            vectors++;
            if ({Dv, Ovf} !== 2'b00) begin
                miscompares++;
                $display("FAIL en_gate[%0d]: Dv/Ovf=%b/%b want 0/0", k, Dv, Ovf);
            end
        end
        En = 1'b1; Din = 4'b1000;
        cycle();
        En = 1'b0; Din = 4'b1111;
        vectors++;
        if ({Dv, Do} !== 3'b1_11) begin
            miscompares++;
            $display("FAIL en_single: Dv/Do=%b/%0d want 1/3", Dv, Do);
        end
        cycle();
        vectors++;
        if (Dv !== 1'b0) begin
            miscompares++;
            $display("FAIL en_only_one: Dv=%b want 0", Dv);
        end
    endtask

    task automatic test_reset_mid_drain();
        En = 1'b1; Dr = 1'b0; Din = 4'b1011;
        cycle();
        // Held Do=0, pending 1010; re-request bit 1 to raise Ovf as well.
        Din = 4'b0010;
        cycle();
        Din = 4'b0000;
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b1_00_1) begin
            miscompares++;
            $display("FAIL mid_setup: Dv/Do/Ovf=%b/%0d/%b want 1/0/1", Dv, Do, Ovf);
        end
        // Advance Do to a non-zero index so the async clear of Do is visible.
        Dr = 1'b1;
        cycle();
        Dr = 1'b0;
        vectors++;
        if ({Dv, Do} !== 3'b1_01) begin
            miscompares++;
            $display("FAIL mid_advance: Dv/Do=%b/%0d want 1/1", Dv, Do);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({Dv, Do, Ovf} !== 4'b0_00_0) begin
            miscompares++;
            $display("FAIL mid_async_reset: Dv/Do/Ovf=%b/%0d/%b want 0/0/0", Dv, Do, Ovf);
        end
        cycle();
        rst_n = 1'b1; Dr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if ({Dv, Ovf} !== 2'b00) begin
                miscompares++;
                $display("FAIL mid_discarded[%0d]: Dv/Ovf=%b/%b want 0/0", k, Dv, Ovf);
            end
        end
        Din = 4'b0100;
        cycle();
        Din = 4'b0000;
        vectors++;
        if ({Dv, Do} !== 3'b1_10) begin
            miscompares++;
            $display("FAIL mid_new_req: Dv/Do=%b/%0d want 1/2", Dv, Do);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_multi_hot();
        test_backpressure();
        test_overflow();
        test_enable_gating();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
